// File: rtl/cym_pkg.sv
// Shared definitions for the measurement scheduler and the downstream counter datapath:
// FSM state encoding, result width and default phase lengths.
package cym_pkg;

   localparam int CYM_RES_W       = 20;
   localparam int CYM_CNT_W       = 32;
   localparam int CYM_SETTLE_DEF  = 16;
   localparam int CYM_GATE_DEF    = 50000;
   localparam int CYM_TIMEOUT_DEF = 1000000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CLR    = 3'd2,
      ST_GATE   = 3'd3,
      ST_WAIT   = 3'd4,
      ST_DONE   = 3'd5
   } cym_state_t;

   // Terminal count of a phase lasting 'cycles' clocks whose counter starts at zero on entry.
   function automatic logic [CYM_CNT_W-1:0] cym_last_cnt(input int cycles);
      return CYM_CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/cym_meas_sched_if.sv
// Request/acknowledge and datapath-control bundle of the measurement scheduler.
// master = scheduler side, slave = requesters plus counter datapath.
interface cym_meas_sched_if #(
   parameter int CH_NUM = 4
) ();
   import cym_pkg::*;

   localparam int CW = $clog2(CH_NUM);

   logic [CH_NUM-1:0]    req;
   logic [CH_NUM-1:0]    ack;
   logic [CW-1:0]        ch_sel;
   logic                 meas_clr;
   logic                 gate_en;
   logic                 meas_done;
   logic [CYM_RES_W-1:0] meas_data;
   logic [CYM_RES_W-1:0] result;
   logic [CW-1:0]        result_ch;
   logic                 result_vld;
   logic                 result_err;

   modport master (
      input  req, meas_done, meas_data,
      output ack, ch_sel, meas_clr, gate_en, result, result_ch, result_vld, result_err
   );

   modport slave (
      output req, meas_done, meas_data,
      input  ack, ch_sel, meas_clr, gate_en, result, result_ch, result_vld, result_err
   );

endinterface

// File: rtl/cym_rr_arb.sv
// Combinational round-robin arbiter: the first requesting channel after 'last',
// wrapping at CH_NUM, wins. Works for non-power-of-two channel counts.
module cym_rr_arb #(
   parameter int CH_NUM = 4,
   parameter int CW     = $clog2(CH_NUM)
) (
   input  logic [CH_NUM-1:0] req,
   input  logic [CW-1:0]     last,
   output logic [CH_NUM-1:0] grant,
   output logic [CW-1:0]     grant_idx,
   output logic              grant_vld
);

   logic [CW-1:0] idx_s;
   logic          hit_s;

   // Priority scan starting one past the previous winner.
   always_comb begin
      grant     = {CH_NUM{1'b0}};
      grant_idx = {CW{1'b0}};
      grant_vld = 1'b0;
      idx_s     = {CW{1'b0}};
      hit_s     = 1'b0;
      for (int i = 1; i <= CH_NUM; i++) begin
         idx_s     = CW'((int'(last) + i) % CH_NUM);
         hit_s     = !grant_vld && req[idx_s];
         grant     = hit_s ? (CH_NUM'(1) << idx_s) : grant;
         grant_idx = hit_s ? idx_s : grant_idx;
         grant_vld = grant_vld | hit_s;
      end
   end

endmodule

// File: rtl/cym_meas_sched.sv
// Measurement scheduler: round-robin grant, then SETTLE/CLR/GATE/WAIT/DONE sequencing
// of the shared frequency counter. Optional WAIT timeout under CYM_SCHED_TIMEOUT_EN.
module cym_meas_sched
   import cym_pkg::*;
#(
   parameter int CH_NUM         = 4,
   parameter int SETTLE_CYCLES  = CYM_SETTLE_DEF,
   parameter int GATE_CYCLES    = CYM_GATE_DEF,
   parameter int TIMEOUT_CYCLES = CYM_TIMEOUT_DEF
) (
   input logic              clk_fs,
   input logic              rst_n,
   cym_meas_sched_if.master bus
);

   localparam int CW = $clog2(CH_NUM);

   cym_state_t           state_r;
   logic [CYM_CNT_W-1:0] cnt_r;
   logic [CW-1:0]        last_r;
   logic [CW-1:0]        ch_sel_r;
   logic [CH_NUM-1:0]    sel_oh_r;
   logic [CH_NUM-1:0]    ack_r;
   logic                 meas_clr_r;
   logic                 gate_en_r;
   logic [CYM_RES_W-1:0] result_r;
   logic [CW-1:0]        result_ch_r;
   logic                 result_vld_r;
`ifdef CYM_SCHED_TIMEOUT_EN
   logic                 result_err_r;
`endif

   logic [CH_NUM-1:0]    grant_s;
   logic [CW-1:0]        grant_idx_s;
   logic                 grant_vld_s;

   cym_rr_arb #(
      .CH_NUM (CH_NUM),
      .CW     (CW)
   ) u_arb (
      .req       (bus.req),
      .last      (last_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_vld (grant_vld_s)
   );

   // Phase sequencer; every datapath- and requester-facing output is a register here.
   always_ff @(posedge clk_fs) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CYM_CNT_W{1'b0}};
         last_r       <= CW'(CH_NUM - 1);
         ch_sel_r     <= {CW{1'b0}};
         sel_oh_r     <= {CH_NUM{1'b0}};
         ack_r        <= {CH_NUM{1'b0}};
         meas_clr_r   <= 1'b0;
         gate_en_r    <= 1'b0;
         result_r     <= {CYM_RES_W{1'b0}};
         result_ch_r  <= {CW{1'b0}};
         result_vld_r <= 1'b0;
`ifdef CYM_SCHED_TIMEOUT_EN
         result_err_r <= 1'b0;
`endif
      end else begin
         meas_clr_r   <= 1'b0;
         result_vld_r <= 1'b0;
         ack_r        <= {CH_NUM{1'b0}};
         case (state_r)
            ST_IDLE: begin
               if (grant_vld_s) begin
                  ch_sel_r <= grant_idx_s;
                  sel_oh_r <= grant_s;
                  last_r   <= grant_idx_s;
                  cnt_r    <= {CYM_CNT_W{1'b0}};
                  state_r  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_r == cym_last_cnt(SETTLE_CYCLES)) begin
                  cnt_r      <= {CYM_CNT_W{1'b0}};
                  meas_clr_r <= 1'b1;
                  state_r    <= ST_CLR;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_CLR: begin
               gate_en_r <= 1'b1;
               cnt_r     <= {CYM_CNT_W{1'b0}};
               state_r   <= ST_GATE;
            end
            ST_GATE: begin
               if (cnt_r == cym_last_cnt(GATE_CYCLES)) begin
                  gate_en_r <= 1'b0;
                  cnt_r     <= {CYM_CNT_W{1'b0}};
                  state_r   <= ST_WAIT;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            // A done pulse wins over a timeout landing on the same edge.
            ST_WAIT: begin
               if (bus.meas_done) begin
                  result_r     <= bus.meas_data;
                  result_ch_r  <= ch_sel_r;
                  result_vld_r <= 1'b1;
                  ack_r        <= sel_oh_r;
`ifdef CYM_SCHED_TIMEOUT_EN
                  result_err_r <= 1'b0;
`endif
                  state_r      <= ST_DONE;
               end
`ifdef CYM_SCHED_TIMEOUT_EN
               else if (cnt_r == cym_last_cnt(TIMEOUT_CYCLES)) begin
                  result_r     <= {CYM_RES_W{1'b0}};
                  result_ch_r  <= ch_sel_r;
                  result_vld_r <= 1'b1;
                  ack_r        <= sel_oh_r;
                  result_err_r <= 1'b1;
                  state_r      <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
`endif
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               gate_en_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ack        = ack_r;
   assign bus.ch_sel     = ch_sel_r;
   assign bus.meas_clr   = meas_clr_r;
   assign bus.gate_en    = gate_en_r;
   assign bus.result     = result_r;
   assign bus.result_ch  = result_ch_r;
   assign bus.result_vld = result_vld_r;
`ifdef CYM_SCHED_TIMEOUT_EN
   assign bus.result_err = result_err_r;
`else
   assign bus.result_err = 1'b0;
`endif

endmodule

// File: tb/tb_cym_meas_sched.sv
// Self-checking bench for cym_meas_sched: directed phases plus randomized requests,
// checked against a round-robin/timing model. Timeout step follows CYM_SCHED_TIMEOUT_EN.
module tb_cym_meas_sched;
   import cym_pkg::*;

   localparam int CH = 4;
   localparam int CW = $clog2(CH);
   localparam int S  = 4;
   localparam int G  = 20;
   localparam int T  = 100;

   logic clk_fs = 1'b0;
   logic rst_n  = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   int              model_last   = CH - 1;
   logic [19:0]     model_result = 20'd0;

   cym_meas_sched_if #(.CH_NUM(CH)) bus ();

   cym_meas_sched #(
      .CH_NUM         (CH),
      .SETTLE_CYCLES  (S),
      .GATE_CYCLES    (G),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk_fs (clk_fs),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk_fs = ~clk_fs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [CH-1:0] r);
      for (int k = 1; k <= CH; k++) begin
         if (r[(model_last + k) % CH]) return (model_last + k) % CH;
      end
      return -1;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_ack"},       32'(bus.ack),        32'd0);
      check({tag, "_ch_sel"},    32'(bus.ch_sel),     32'd0);
      check({tag, "_gate_en"},   32'(bus.gate_en),    32'd0);
      check({tag, "_meas_clr"},  32'(bus.meas_clr),   32'd0);
      check({tag, "_result"},    32'(bus.result),     32'd0);
      check({tag, "_result_ch"}, 32'(bus.result_ch),  32'd0);
      check({tag, "_vld"},       32'(bus.result_vld), 32'd0);
      check({tag, "_err"},       32'(bus.result_err), 32'd0);
   endtask

   // One full measurement, called on a negedge while the DUT is in IDLE.
   task automatic measure(input string tag, input int done_at, input logic [19:0] data,
                          input bit spurious, input bit drop_req, input bit expect_to);
      int          exp_ch;
      int          n;
      int          gcnt;
      int          w;
      bit          sel_ok;
      logic        exp_err;
      logic [CH-1:0] one;
      exp_ch = model_grant(bus.req);
      check({tag, "_has_req"}, 32'(exp_ch >= 0), 32'd1);
      if (exp_ch < 0) return;
      n = 0;
      while (bus.meas_clr !== 1'b1 && n < 200) begin
         @(negedge clk_fs);
         n++;
         if (drop_req && n == 2) bus.req[exp_ch] = 1'b0;
      end
      check({tag, "_clr_latency"}, 32'(n), 32'(S + 1));
      check({tag, "_grant"}, 32'(bus.ch_sel), 32'(exp_ch));
      model_last = exp_ch;
      sel_ok = 1'b1;
      @(negedge clk_fs);
      check({tag, "_clr_one_pulse"}, 32'(bus.meas_clr), 32'd0);
      gcnt = 0;
      while (bus.gate_en === 1'b1 && gcnt < 500) begin
         gcnt++;
         if (bus.ch_sel !== CW'(exp_ch)) sel_ok = 1'b0;
         if (spurious && gcnt == 3) begin
            bus.meas_done = 1'b1;
            bus.meas_data = 20'd7;
         end else begin
            bus.meas_done = 1'b0;
         end
         @(negedge clk_fs);
      end
      check({tag, "_gate_len"}, 32'(gcnt), 32'(G));
      check({tag, "_result_held"}, 32'(bus.result), 32'(model_result));
      w = 1;
      if (!expect_to) begin
         while (w < done_at) begin
            if (bus.ch_sel !== CW'(exp_ch)) sel_ok = 1'b0;
            @(negedge clk_fs);
            w++;
         end
         check({tag, "_no_early_vld"}, 32'(bus.result_vld), 32'd0);
         bus.meas_done = 1'b1;
         bus.meas_data = data;
         @(negedge clk_fs);
         bus.meas_done = 1'b0;
         model_result  = data;
         exp_err       = 1'b0;
      end else begin
         while (bus.result_vld !== 1'b1 && w < 1000) begin
            @(negedge clk_fs);
            w++;
         end
         check({tag, "_timeout_latency"}, 32'(w), 32'(T + 1));
         model_result = 20'd0;
         exp_err      = 1'b1;
      end
      one = 1;
      check({tag, "_vld"},       32'(bus.result_vld), 32'd1);
      check({tag, "_ack"},       32'(bus.ack),        32'(one << exp_ch));
      check({tag, "_result"},    32'(bus.result),     32'(model_result));
      check({tag, "_result_ch"}, 32'(bus.result_ch),  32'(exp_ch));
      check({tag, "_err"},       32'(bus.result_err), 32'(exp_err));
      check({tag, "_sel_stable"}, 32'(sel_ok && bus.ch_sel === CW'(exp_ch)), 32'd1);
      @(negedge clk_fs);
      check({tag, "_vld_one_cycle"}, 32'(bus.result_vld), 32'd0);
      check({tag, "_ack_one_cycle"}, 32'(bus.ack),        32'd0);
   endtask

   initial begin
      int  n;
      bit  idle_ok;
      bus.req       = 4'b0000;
      bus.meas_done = 1'b0;
      bus.meas_data = 20'd0;

      // Power-on reset
      repeat (3) @(negedge clk_fs);
      check_quiet("por");
      rst_n = 1'b1;
      @(negedge clk_fs);

      // Reset in the middle of GATE aborts without ack and restores channel-0 priority
      bus.req = 4'b0010;
      n = 0;
      while (bus.gate_en !== 1'b1 && n < 100) begin
         @(negedge clk_fs);
         n++;
      end
      check("mid_rst_reach_gate", 32'(bus.gate_en), 32'd1);
      repeat (5) @(negedge clk_fs);
      rst_n   = 1'b0;
      bus.req = 4'b0101;
      repeat (3) @(negedge clk_fs);
      check_quiet("mid_rst");
      rst_n      = 1'b1;
      model_last = CH - 1;
      measure("after_rst", 3, 20'd4321, 1'b0, 1'b0, 1'b0);
      bus.req = 4'b0000;

      // Single request on channel 2
      bus.req = 4'b0100;
      measure("single", 5, 20'd12345, 1'b0, 1'b0, 1'b0);
      bus.req = 4'b0000;

      // All channels held: five back-to-back grants in rotation
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         measure("rr", int'($urandom_range(1, 8)), 20'($urandom), 1'b0, 1'b0, 1'b0);
      end
      bus.req = 4'b0000;

      // Done pulse during GATE is ignored
      bus.req = 4'b1000;
      measure("spurious", 3, 20'd999, 1'b1, 1'b0, 1'b0);
      bus.req = 4'b0000;

      // Requester withdraws during SETTLE; ack still issued, then nothing granted
      bus.req = 4'b0010;
      measure("withdrawn", 2, 20'd555, 1'b0, 1'b1, 1'b0);
      idle_ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (bus.meas_clr !== 1'b0 || bus.gate_en !== 1'b0 || bus.ch_sel !== 2'd1) idle_ok = 1'b0;
         @(negedge clk_fs);
      end
      check("withdrawn_no_regrant", 32'(idle_ok), 32'd1);

      bus.req = 4'b0001;
`ifdef CYM_SCHED_TIMEOUT_EN
      measure("timeout", 0, 20'd0, 1'b0, 1'b0, 1'b1);
`else
      measure("no_timeout", 3 * T + 5, 20'd777, 1'b0, 1'b0, 1'b0);
`endif
      bus.req = 4'b0000;

      // Randomized request patterns against the round-robin model
      for (int i = 0; i < 6; i++) begin
         bus.req = 4'($urandom_range(1, 15));
         measure("rand", int'($urandom_range(1, 10)), 20'($urandom), 1'b0, 1'b0, 1'b0);
      end
      bus.req = 4'b0000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
